// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the led_pwm block.
// The mode encoding is what cfg_mode carries on the configuration port.
package led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        OFF           = 2'd0,
        ON            = 2'd1,
        PWM           = 2'd2,
        BLINK_BREATHE = 2'd3
    } led_mode_t;

endpackage : led_pkg

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler plus phase counter for the LED PWM frame.
// tick fires once every PRESCALE clocks. phase advances on each tick.
// boundary marks the tick on which phase wraps to zero (end of frame).
module led_tick_gen #(
    parameter int PRESCALE = 5,
    parameter int DUTY_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              tick,
    output logic [DUTY_W-1:0] phase,
    output logic              boundary
);

    localparam int                PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] PHASE_MAX = {DUTY_W{1'b1}};

    logic [PRE_W-1:0]  pre_q,   pre_d;
    logic [DUTY_W-1:0] phase_q, phase_d;

    // Next prescaler/phase values and the tick/boundary strobes.
    always_comb begin
        tick     = (pre_q == PRE_MAX);
        boundary = tick && (phase_q == PHASE_MAX);
        if (tick) begin
            pre_d   = '0;
            phase_d = phase_q + DUTY_W'(1);
        end else begin
            pre_d   = pre_q + PRE_W'(1);
            phase_d = phase_q;
        end
    end

    // Counter state; reset restarts the frame at phase 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            phase_q <= '0;
        end else begin
            pre_q   <= pre_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule : led_tick_gen

// File: rtl/led_pwm.sv
// led_pwm: NUM_LEDS independent LED channels (off / on / PWM / blink).
// Configuration goes through a single pending slot. It only takes effect
// at a frame boundary, so outputs never change mid-frame because of a write.
// Build macro LED_PWM_BREATHE_EN: mode 3 becomes a triangular breathe ramp
// (duty +1 per frame up to max, then -1 per frame back to 0). Without it,
// mode 3 toggles the LED every frame.
module led_pwm
    import led_pkg::*;
#(
    parameter int  NUM_LEDS = 4,
    parameter int  PRESCALE = 5,
    parameter int  DUTY_W   = 4,
    localparam int CHAN_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [DUTY_W-1:0]   cfg_duty,
    output logic [NUM_LEDS-1:0] led,
    output logic                frame_start
);

    logic              tick_s, boundary_s, frame_edge_s;
    logic [DUTY_W-1:0] phase_s;
    logic              chan_ok_s, accept_s;

    logic              pend_q, pend_d;
    logic [CHAN_W-1:0] pend_chan_q, pend_chan_d;
    led_mode_t         pend_mode_q, pend_mode_d;
    logic [DUTY_W-1:0] pend_duty_q, pend_duty_d;

    logic              app_valid_s;
    logic [CHAN_W-1:0] app_chan_s;
    led_mode_t         app_mode_s;
    logic [DUTY_W-1:0] app_duty_s;

    led_mode_t         mode_q [NUM_LEDS];
    led_mode_t         mode_d [NUM_LEDS];
    logic [DUTY_W-1:0] duty_q [NUM_LEDS];
    logic [DUTY_W-1:0] duty_d [NUM_LEDS];
`ifdef LED_PWM_BREATHE_EN
    localparam logic [DUTY_W-1:0] LVL_MAX = {DUTY_W{1'b1}};
    logic [DUTY_W-1:0] lvl_q [NUM_LEDS];
    logic [DUTY_W-1:0] lvl_d [NUM_LEDS];
    logic [NUM_LEDS-1:0] dir_q, dir_d;   // 0 = ramping up, 1 = ramping down
`else
    logic [NUM_LEDS-1:0] tog_q, tog_d;
`endif
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                fs_q, fs_d;

    led_tick_gen #(
        .PRESCALE (PRESCALE),
        .DUTY_W   (DUTY_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick_s),
        .phase    (phase_s),
        .boundary (boundary_s)
    );

    // Boundary is only defined on a tick; qualify it explicitly.
    assign frame_edge_s = tick_s & boundary_s;
    assign cfg_ready    = ~pend_q;
    assign accept_s     = cfg_valid & ~pend_q;
    assign chan_ok_s    = ({1'b0, cfg_chan} < (CHAN_W + 1)'(NUM_LEDS));

    // Select which write lands at the boundary: the pending one, or one accepted on the boundary cycle itself.
    always_comb begin
        if (pend_q) begin
            app_valid_s = 1'b1;
            app_chan_s  = pend_chan_q;
            app_mode_s  = pend_mode_q;
            app_duty_s  = pend_duty_q;
        end else if (accept_s && chan_ok_s) begin
            app_valid_s = 1'b1;
            app_chan_s  = cfg_chan;
            app_mode_s  = led_mode_t'(cfg_mode);
            app_duty_s  = cfg_duty;
        end else begin
            app_valid_s = 1'b0;
            app_chan_s  = pend_chan_q;
            app_mode_s  = pend_mode_q;
            app_duty_s  = pend_duty_q;
        end
    end

    // Pending slot: filled by an accepted in-range write, drained at every boundary.
    always_comb begin
        pend_d      = pend_q;
        pend_chan_d = pend_chan_q;
        pend_mode_d = pend_mode_q;
        pend_duty_d = pend_duty_q;
        if (frame_edge_s) begin
            pend_d = 1'b0;
        end else if (accept_s && chan_ok_s) begin
            pend_d      = 1'b1;
            pend_chan_d = cfg_chan;
            pend_mode_d = led_mode_t'(cfg_mode);
            pend_duty_d = cfg_duty;
        end else begin
            pend_d = pend_q;
        end
    end

    // Per-channel active config and frame-stepped state; only changes at a boundary.
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            mode_d[i] = mode_q[i];
            duty_d[i] = duty_q[i];
`ifdef LED_PWM_BREATHE_EN
            lvl_d[i] = lvl_q[i];
            dir_d[i] = dir_q[i];
            if (frame_edge_s && app_valid_s && (app_chan_s == CHAN_W'(i))) begin
                mode_d[i] = app_mode_s;
                duty_d[i] = app_duty_s;
                lvl_d[i]  = '0;
                dir_d[i]  = 1'b0;
            end else if (frame_edge_s && (mode_q[i] == BLINK_BREATHE)) begin
                if (!dir_q[i]) begin
                    if (lvl_q[i] == LVL_MAX) begin
                        dir_d[i] = 1'b1;
                        lvl_d[i] = LVL_MAX - DUTY_W'(1);
                    end else begin
                        lvl_d[i] = lvl_q[i] + DUTY_W'(1);
                    end
                end else begin
                    if (lvl_q[i] == '0) begin
                        dir_d[i] = 1'b0;
                        lvl_d[i] = DUTY_W'(1);
                    end else begin
                        lvl_d[i] = lvl_q[i] - DUTY_W'(1);
                    end
                end
            end else begin
                lvl_d[i] = lvl_q[i];
            end
`else
            tog_d[i] = tog_q[i];
            if (frame_edge_s && app_valid_s && (app_chan_s == CHAN_W'(i))) begin
                mode_d[i] = app_mode_s;
                duty_d[i] = app_duty_s;
                tog_d[i]  = 1'b0;
            end else if (frame_edge_s && (mode_q[i] == BLINK_BREATHE)) begin
                tog_d[i] = ~tog_q[i];
            end else begin
                tog_d[i] = tog_q[i];
            end
`endif
        end
    end

    // LED drive decode from the current phase; registered below for glitch-free outputs.
    always_comb begin
        fs_d = frame_edge_s;
        for (int i = 0; i < NUM_LEDS; i++) begin
            case (mode_q[i])
                OFF:           led_d[i] = 1'b0;
                ON:            led_d[i] = 1'b1;
                PWM:           led_d[i] = (phase_s < duty_q[i]);
`ifdef LED_PWM_BREATHE_EN
                BLINK_BREATHE: led_d[i] = (phase_s < lvl_q[i]);
`else
                BLINK_BREATHE: led_d[i] = tog_q[i];
`endif
                default:       led_d[i] = 1'b0;
            endcase
        end
    end

    // State and output registers; reset drops any pending write and forces all channels off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_chan_q <= '0;
            pend_mode_q <= OFF;
            pend_duty_q <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mode_q[i] <= OFF;
                duty_q[i] <= '0;
`ifdef LED_PWM_BREATHE_EN
                lvl_q[i]  <= '0;
`endif
            end
`ifdef LED_PWM_BREATHE_EN
            dir_q <= '0;
`else
            tog_q <= '0;
`endif
            led_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            pend_chan_q <= pend_chan_d;
            pend_mode_q <= pend_mode_d;
            pend_duty_q <= pend_duty_d;
            mode_q      <= mode_d;
            duty_q      <= duty_d;
`ifdef LED_PWM_BREATHE_EN
            lvl_q <= lvl_d;
            dir_q <= dir_d;
`else
            tog_q <= tog_d;
`endif
            led_q <= led_d;
            fs_q  <= fs_d;
        end
    end

    assign led         = led_q;
    assign frame_start = fs_q;

endmodule : led_pwm
